// File: rtl/vlane_normalizer_pkg.sv
// Shared vector-lane definitions: normalizer opcodes and the count-width helper.
package vlane_normalizer_pkg;

  localparam logic NORM_OP_CLZ = 1'b0;
  localparam logic NORM_OP_CLS = 1'b1;

  // The count must reach WIDTH itself (all-zero CLZ), hence one bit more than log2.
  function automatic int norm_cnt_w(input int log2width);
    return log2width + 1;
  endfunction

endpackage

// File: rtl/vlane_normalizer_lzc.sv
// Purely combinational leading-zero counter; an all-zero input yields WIDTH.
module vlane_lzc
  import vlane_normalizer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LOG2WIDTH = 5,
  localparam int CNT_W    = norm_cnt_w(LOG2WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        cnt   = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vlane_normalizer.sv
// CLZ/CLS normalizer with valid/ready flow control.
// Define VLANE_NORM_PIPE_BREAK_EN for a two-stage pipe (count | shift); default is one stage.
module vlane_normalizer
  import vlane_normalizer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LOG2WIDTH = 5,
  localparam int CNT_W    = norm_cnt_w(LOG2WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] count
);

  // Left-only barrel shift; the top stage (shift by WIDTH) clears the word.
  function automatic logic [WIDTH-1:0] shl_barrel(input logic [WIDTH-1:0] a,
                                                  input logic [CNT_W-1:0] s);
    logic [WIDTH-1:0] v;
    v = a;
    for (int k = 0; k < CNT_W; k++) begin
      if (s[k]) v = v << (1 << k);
    end
    return v;
  endfunction

  logic [WIDTH-1:0] lzc_in;
  logic [WIDTH-1:0] cls_vec;
  logic [CNT_W-1:0] lzc_cnt;
  logic [CNT_W-1:0] norm_cnt;

  // CLS: each bit of cls_vec flags a sign change; the masked MSB makes the count one too high.
  always_comb begin
    cls_vec          = opA ^ (opA >> 1);
    cls_vec[WIDTH-1] = 1'b0;
    lzc_in           = (op == NORM_OP_CLS) ? cls_vec : opA;
    norm_cnt         = (op == NORM_OP_CLS) ? (lzc_cnt - CNT_W'(1)) : lzc_cnt;
  end

  vlane_lzc #(
    .WIDTH     (WIDTH),
    .LOG2WIDTH (LOG2WIDTH)
  ) u_lzc (
    .din (lzc_in),
    .cnt (lzc_cnt)
  );

`ifdef VLANE_NORM_PIPE_BREAK_EN

  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] opa_p1_q, opa_p1_d;
  logic [CNT_W-1:0] cnt_p1_q, cnt_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] res_p2_q, res_p2_d;
  logic [CNT_W-1:0] cnt_p2_q, cnt_p2_d;
  logic             p1_free, p2_free;

  always_comb begin
    p2_free  = !vld_p2_q || out_ready;
    p1_free  = !vld_p1_q || p2_free;
    in_ready = p1_free;

    vld_p1_d = vld_p1_q;
    opa_p1_d = opa_p1_q;
    cnt_p1_d = cnt_p1_q;
    vld_p2_d = vld_p2_q;
    res_p2_d = res_p2_q;
    cnt_p2_d = cnt_p2_q;

    if (p1_free) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        opa_p1_d = opA;
        cnt_p1_d = norm_cnt;
      end
    end

    if (p2_free) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        res_p2_d = shl_barrel(opa_p1_q, cnt_p1_q);
        cnt_p2_d = cnt_p1_q;
      end
    end
  end

  // S1: operand and count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q <= 1'b0;
      opa_p1_q <= '0;
      cnt_p1_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      opa_p1_q <= opa_p1_d;
      cnt_p1_q <= cnt_p1_d;
    end
  end

  // S2: shifted result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= '0;
      cnt_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      res_p2_q <= res_p2_d;
      cnt_p2_q <= cnt_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign result    = res_p2_q;
  assign count     = cnt_p2_q;

`else

  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] res_p1_q, res_p1_d;
  logic [CNT_W-1:0] cnt_p1_q, cnt_p1_d;

  always_comb begin
    in_ready = !vld_p1_q || out_ready;
    vld_p1_d = vld_p1_q;
    res_p1_d = res_p1_q;
    cnt_p1_d = cnt_p1_q;
    if (in_ready) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        res_p1_d = shl_barrel(opA, norm_cnt);
        cnt_p1_d = norm_cnt;
      end
    end
  end

  // S1: count and shift in one combinational stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q <= 1'b0;
      res_p1_q <= '0;
      cnt_p1_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      res_p1_q <= res_p1_d;
      cnt_p1_q <= cnt_p1_d;
    end
  end

  assign out_valid = vld_p1_q;
  assign result    = res_p1_q;
  assign count     = cnt_p1_q;

`endif

endmodule

// File: tb/tb_vlane_normalizer.sv
// Directed self-checking bench for vlane_normalizer (either pipeline configuration).
module tb_vlane_normalizer;

`ifdef VLANE_NORM_PIPE_BREAK_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] opA = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;

  vlane_normalizer #(.WIDTH(32), .LOG2WIDTH(5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic do_op(input logic [31:0] a, input logic o, input int exp_cnt,
                       input logic [31:0] exp_res, input string name);
    int n;
    int lat;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; opA = a; op = o;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", name, out_valid); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT); end
    checks++; if (count !== 6'(exp_cnt)) begin errors++; $display("FAIL %s_count got %0d want %0d", name, count, exp_cnt); end
    checks++; if (result !== exp_res) begin errors++; $display("FAIL %s_result got %h want %h", name, result, exp_res); end
  endtask

  task automatic test_clz();
    do_op(32'h0001_0000, 1'b0, 15, 32'h8000_0000, "clz_bit16");
    do_op(32'h0000_0000, 1'b0, 32, 32'h0000_0000, "clz_zero");
    do_op(32'h8000_0000, 1'b0, 0,  32'h8000_0000, "clz_msb");
    do_op(32'h0000_0001, 1'b0, 31, 32'h8000_0000, "clz_one");
    do_op(32'h0000_1234, 1'b0, 19, 32'h91A0_0000, "clz_1234");
  endtask

  task automatic test_cls();
    do_op(32'hFFFF_FFFF, 1'b1, 31, 32'h8000_0000, "cls_allones");
    do_op(32'hFFF0_0000, 1'b1, 11, 32'h8000_0000, "cls_fff");
    do_op(32'h7FFF_FFFF, 1'b1, 0,  32'h7FFF_FFFF, "cls_7fff");
    do_op(32'h0000_0000, 1'b1, 31, 32'h0000_0000, "cls_zero");
    do_op(32'h0000_1234, 1'b1, 18, 32'h48D0_0000, "cls_1234");
    do_op(32'h8000_0000, 1'b1, 0,  32'h8000_0000, "cls_min");
  endtask

  task automatic test_back_to_back();
    int got_cnt[8];
    logic [31:0] got_res[8];
    int got_cyc[8];
    int nrx;
    int stall_seen;
    nrx = 0;
    stall_seen = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          in_valid = 1'b1; op = 1'b0; opA = 32'h0000_0003 << (3 * i);
          if (!in_ready) stall_seen++;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (out_valid && nrx < 8) begin
            got_cnt[nrx] = int'(count); got_res[nrx] = result; got_cyc[nrx] = c; nrx++;
          end
        end
      end
    join
    checks++; if (stall_seen !== 0) begin errors++; $display("FAIL b2b_in_ready stalls got %0d want 0", stall_seen); end
    checks++; if (nrx !== 8) begin errors++; $display("FAIL b2b_count_results got %0d want 8", nrx); end
    if (nrx == 8) begin
      checks++; if (got_cyc[0] !== LAT) begin errors++; $display("FAIL b2b_first_cycle got %0d want %0d", got_cyc[0], LAT); end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got_cyc[k] !== got_cyc[0] + k || got_cnt[k] !== 30 - 3 * k || got_res[k] !== 32'hC000_0000) begin
          errors++;
          $display("FAIL b2b_item%0d got cyc=%0d cnt=%0d res=%h want cyc=%0d cnt=%0d res=c0000000",
                   k, got_cyc[k], got_cnt[k], got_res[k], got_cyc[0] + k, 30 - 3 * k);
        end
      end
    end
  endtask

  task automatic test_stall();
    int acc;
    int have_ref;
    int unstable;
    logic [31:0] ref_res;
    logic [5:0]  ref_cnt;
    int got_cnt[8];
    int nrx;
    acc = 0; have_ref = 0; unstable = 0; nrx = 0;
    ref_res = '0; ref_cnt = '0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = 1'b1; op = 1'b0; opA = 32'h0000_0100 << acc;
      if (out_valid) begin
        if (have_ref == 0) begin ref_res = result; ref_cnt = count; have_ref = 1; end
        else if (result !== ref_res || count !== ref_cnt) unstable++;
      end
      if (in_ready) acc++;
    end
    checks++; if (acc !== LAT) begin errors++; $display("FAIL stall_accepted got %0d want %0d", acc, LAT); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got %b want 1", out_valid); end
    checks++; if (unstable !== 0 || have_ref !== 1) begin errors++; $display("FAIL stall_stable got changes=%0d seen=%0d want 0 1", unstable, have_ref); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && nrx < 8) begin got_cnt[nrx] = int'(count); nrx++; end
      @(negedge clk);
    end
    checks++; if (nrx !== LAT) begin errors++; $display("FAIL stall_drain_count got %0d want %0d", nrx, LAT); end
    for (int k = 0; k < LAT; k++) begin
      checks++;
      if (k >= nrx || got_cnt[k] !== 23 - k) begin
        errors++; $display("FAIL stall_drain_item%0d got %0d want %0d", k, (k < nrx) ? got_cnt[k] : -1, 23 - k);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    stale = 0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b0; opA = 32'h0000_0010;
    @(negedge clk);
    opA = 32'h0000_0020;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got %b want 1", out_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", count); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", result); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rstmid_stale got %0d want 0", stale); end
    do_op(32'h0000_0001, 1'b0, 31, 32'h8000_0000, "post_reset");
  endtask

  initial begin
    test_reset();
    test_clz();
    test_cls();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
